// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(16);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/dmem_lat_cnt.sv
// Loadable latency down-counter; holds at zero and flags terminal count.
module dmem_lat_cnt
    import dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_stall_resp.sv
// Multi-cycle data-memory responder: one request at a time, Done after LAT cycles.
// Build option: DMEM_ALIGN_CHECK_EN flags odd byte addresses via Err.
//
// state | meaning
// IDLE  | no request in flight, may accept
// BUSY  | request latched, latency counter running
// DONE  | Done pulse cycle; may accept the next request back-to-back
module dmem_stall_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [15:0]       Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              halt,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] DataOut,
    output logic              Err
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    state_t              r_state;
    state_t              w_next;
    op_t                 r_op;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mis;
    logic [DATA_W-1:0]   r_dout;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

    logic                w_req;
    logic                w_accept;
    logic                w_zero;
    logic                w_commit;
    logic                w_mis;
    logic                w_unused;

    assign w_req    = MemRead | MemWrite;
    assign w_accept = w_req & ~halt & ((r_state == IDLE) | (r_state == DONE));
    assign w_commit = (r_state == BUSY) & w_zero;
    assign Stall    = w_req & ~w_accept;
    assign Done     = (r_state == DONE);
    assign DataOut  = r_dout;
    assign Err      = r_err;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = Addr[0];
`else
    assign w_mis = 1'b0;
`endif

    // Upper address bits wrap onto the array; bit 0 only matters for the align check.
    assign w_unused = ^{Addr[15:ADDR_W+1], Addr[0]};

    dmem_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (LAT_M1),
        .i_dec      (r_state == BUSY),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (w_zero) w_next = DONE;
            DONE:    w_next = w_accept ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_idx   <= '0;
            r_wdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= MemWrite ? OP_WR : OP_RD;
                r_idx   <= Addr[ADDR_W:1];
                r_wdata <= DataIn;
                r_mis   <= w_mis;
            end
        end
    end

    // Outputs are only non-zero during the single DONE cycle that follows a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
            r_err  <= 1'b0;
        end else if (w_commit) begin
            r_dout <= ((r_op == OP_RD) && !r_mis) ? r_mem[r_idx] : '0;
            r_err  <= r_mis;
        end else begin
            r_dout <= '0;
            r_err  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit && (r_op == OP_WR) && !r_mis) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_stall_resp.sv
// Scoreboard bench for dmem_stall_resp: driver pushes expectations, monitor checks Done pulses.
module tb_dmem_stall_resp;

    localparam int ADDR_W = 10;
    localparam int LAT    = 4;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, halt;
    logic [15:0] Addr, DataIn;
    logic        Stall, Done, Err;
    logic [15:0] DataOut;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          last_a = -100;
    exp_t        q[$];
    logic [15:0] mdl [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_stall_resp #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .DataIn(DataIn), .halt(halt), .Stall(Stall),
        .Done(Done), .DataOut(DataOut), .Err(Err)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, want, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (cyc >= last_a) && (cyc < last_a + LAT);
    endfunction

    // Reference model: the array as a map of word index -> value, updated at accept.
    task automatic push_exp(bit rd, bit wr, logic [15:0] addr, logic [15:0] data, int a);
        exp_t e;
        int   idx;
        bit   mis;
        idx = (int'(addr) / 2) % (1 << ADDR_W);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = addr[0];
`else
        mis = 1'b0;
`endif
        e.err  = mis;
        e.cyc  = a + LAT;
        e.data = 16'h0000;
        if (wr) begin
            if (!mis) mdl[idx] = data;
        end else if (rd && !mis) begin
            e.data = mdl.exists(idx) ? mdl[idx] : 16'h0000;
        end
        q.push_back(e);
    endtask

    task automatic issue(bit rd, bit wr, logic [15:0] addr, logic [15:0] data, int halt_cyc);
        bit fin = 1'b0;
        bit exp_stall;
        int n = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Addr = addr; DataIn = data;
        halt = (halt_cyc > 0);
        while (!fin) begin
            #1;
            exp_stall = (rd | wr) & (halt | model_busy());
            chk("stall", {31'b0, Stall}, {31'b0, exp_stall});
            if (!exp_stall) begin
                push_exp(rd, wr, addr, data, cyc + 1);
                last_a = cyc + 1;
                fin = 1'b1;
                @(posedge clk);
            end else begin
                n++;
                if (n > 50) begin
                    total++; bad++;
                    $display("FAIL accept_timeout: no accept after %0d cycles", n);
                    fin = 1'b1;
                end
                @(negedge clk);
                if (halt_cyc > 0) halt_cyc--;
                halt = (halt_cyc > 0);
            end
        end
    endtask

    task automatic idle(int n);
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0; halt = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (Done) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done: Done=1 with nothing outstanding (cyc %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("dataout", {16'b0, DataOut}, {16'b0, e.data});
                    chk("err", {31'b0, Err}, {31'b0, e.err});
                end
            end else begin
                chk("idle_dataout", {16'b0, DataOut}, 32'h0);
                chk("idle_err", {31'b0, Err}, 32'h0);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    total++; bad++;
                    $display("FAIL missed_done: expected Done at cyc %0d but Done was low", q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int a;
        int n;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; halt = 1'b0;
        Addr = 16'h0; DataIn = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_done", {31'b0, Done}, 32'h0);
        chk("rst_dataout", {16'b0, DataOut}, 32'h0);
        chk("rst_err", {31'b0, Err}, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);

        // write then read held through BUSY, accepted in the DONE cycle
        issue(0, 1, 16'h0010, 16'hBEEF, 0);
        issue(1, 0, 16'h0010, 16'h0000, 0);
        idle(LAT + 2);

        // reset during BUSY aborts the write
        issue(0, 1, 16'h0020, 16'h5555, 0);
        idle(LAT + 2);
        @(negedge clk);
        MemWrite = 1'b1; Addr = 16'h0020; DataIn = 16'h1234;
        #1;
        chk("abort_stall", {31'b0, Stall}, 32'h0);
        a = cyc + 1;
        @(negedge clk);
        MemWrite = 1'b0;
        while (cyc < a + 2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_done", {31'b0, Done}, 32'h0);
        chk("abort_dataout", {16'b0, DataOut}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_a = -100;
        issue(1, 0, 16'h0020, 16'h0000, 0);
        idle(LAT + 2);

        // halt blocks accepts in IDLE; halt during BUSY does not stop completion
        issue(1, 0, 16'h0010, 16'h0000, 3);
        @(negedge clk);
        MemRead = 1'b0; halt = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        halt = 1'b0;
        idle(2);

        // read+write together acts as a write
        issue(1, 1, 16'h0030, 16'h00A5, 0);
        issue(1, 0, 16'h0030, 16'h0000, 0);
        idle(LAT + 2);

        // odd address: flagged and dropped with the align check, else same word
        issue(0, 1, 16'h0040, 16'h5A5A, 0);
        issue(0, 1, 16'h0041, 16'h7777, 0);
        issue(1, 0, 16'h0040, 16'h0000, 0);
        idle(LAT + 2);

        // upper address bits wrap onto the array
        issue(0, 1, 16'hF8A0, 16'h3C3C, 0);
        issue(1, 0, 16'h00A0, 16'h0000, 0);
        idle(2);

        for (int i = 0; i < 16; i++) issue(0, 1, 16'(((256 + i) * 2)), 16'($urandom), 0);
        for (int k = 0; k < 60; k++) begin
            logic [15:0] ad;
            int          gap;
            ad = 16'(((256 + $urandom_range(0, 15)) * 2) + ($urandom_range(0, 31) * 2048));
            if ($urandom_range(0, 1) == 1) issue(0, 1, ad, 16'($urandom), 0);
            else                           issue(1, 0, ad, 16'h0000, 0);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(1);

        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d responses still outstanding", q.size());
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
